// File: rtl/sipo_pkg.sv
// sipo_pkg: frame format and receiver state encoding shared by both ends of the serial link
package sipo_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/sipo_receiver.sv
// sipo_receiver: strobe-sampled serial frame receiver with a valid/ack parallel output
module sipo_receiver
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ack,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state, state_nx;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg, shift_nx;
    logic             last_bit, stop_hit, good_stop;

    assign last_bit  = bit_cnt == CW'(WIDTH - 1);
    assign stop_hit  = bit_en && state == ST_STOP;
    assign good_stop = stop_hit && ser_in == STOP_BIT;
    assign shift_nx  = MSB_FIRST ? {shift_reg[WIDTH-2:0], ser_in} : {ser_in, shift_reg[WIDTH-1:1]};

    always_comb
        state_nx = !bit_en           ? state :
                   state == ST_IDLE  ? (ser_in == START_BIT ? ST_DATA : ST_IDLE) :
                   state == ST_DATA  ? (last_bit ? ST_STOP : ST_DATA) :
                   ST_IDLE;

    // busy mirrors the next state so it is a plain register aligned with state
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= state_nx != ST_IDLE;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            bit_cnt <= '0;
        else if (bit_en)
            bit_cnt <= state == ST_IDLE              ? '0 :
                       state == ST_DATA && !last_bit ? bit_cnt + 1'b1 :
                       bit_cnt;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            shift_reg <= '0;
        else if (bit_en && state == ST_DATA)
            shift_reg <= shift_nx;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            par_out   <= '0;
            par_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            par_out   <= good_stop ? shift_reg : par_out;
            par_valid <= good_stop || (par_valid && !par_ack);
            frame_err <= stop_hit && ser_in != STOP_BIT;
            overrun   <= good_stop && par_valid && !par_ack;
        end
endmodule

// File: tb/tb_sipo_receiver.sv
// tb_sipo_receiver: scoreboard bench driving an MSB-first and an LSB-first receiver from one serial stream
module tb_sipo_receiver;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_en = 1'b0;
    logic       ser_in = 1'b1;
    logic       par_ack = 1'b0;
    logic [7:0] out_m, out_l;
    logic       valid_m, valid_l, err_m, err_l, ovr_m, ovr_l, busy_m, busy_l;

    typedef struct {
        logic [7:0] wm;
        logic [7:0] wl;
        logic       v;
        logic       e;
        logic       o;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mv = 1'b0;
    logic [7:0] mwm = '0;
    logic [7:0] mwl = '0;
    bit         prev_busy = 1'b0;

    always #5 clk = ~clk;

    sipo_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .bit_en(bit_en), .ser_in(ser_in),
        .par_out(out_m), .par_valid(valid_m), .par_ack(par_ack),
        .frame_err(err_m), .overrun(ovr_m), .busy(busy_m)
    );

    sipo_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .bit_en(bit_en), .ser_in(ser_in),
        .par_out(out_l), .par_valid(valid_l), .par_ack(par_ack),
        .frame_err(err_l), .overrun(ovr_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input bit b, input int gap, input bit ack);
        bit_en = 1'b0;
        repeat (gap - 1) tick();
        bit_en  = 1'b1;
        ser_in  = b;
        par_ack = ack;
        tick();
        bit_en  = 1'b0;
        ser_in  = 1'b1;
        par_ack = 1'b0;
    endtask

    // w is in transmission order: w[7] goes on the line first
    task automatic send_frame(input logic [7:0] w, input bit stop, input int gap, input bit ack);
        exp_t e;
        send_bit(1'b0, gap, 1'b0);
        for (int i = 7; i >= 0; i--) send_bit(w[i], gap, 1'b0);
        e.o = stop && mv && !ack;
        e.e = !stop;
        if (ack) mv = 1'b0;
        if (stop) begin
            mwm = w;
            mwl = rev8(w);
            mv  = 1'b1;
        end
        e.v  = mv;
        e.wm = mwm;
        e.wl = mwl;
        q.push_back(e);
        send_bit(stop, gap, ack);
    endtask

    task automatic do_ack();
        par_ack = 1'b1;
        tick();
        par_ack = 1'b0;
        mv = 1'b0;
        chk("ack_valid_m", valid_m, 0);
        chk("ack_valid_l", valid_l, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_m"}, out_m, 0);
        chk({tag, "_out_l"}, out_l, 0);
        chk({tag, "_valid"}, {valid_m, valid_l}, 0);
        chk({tag, "_busy"}, {busy_m, busy_l}, 0);
        chk({tag, "_pulses"}, {err_m, err_l, ovr_m, ovr_l}, 0);
    endtask

    // frame completion is seen as busy falling; everything else must be pulse-free
    always @(negedge clk) begin
        if (!rst) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy_m) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame_end", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("par_out_msb", out_m, e.wm);
                    chk("par_out_lsb", out_l, e.wl);
                    chk("par_valid", {valid_m, valid_l}, {e.v, e.v});
                    chk("frame_err", {err_m, err_l}, {e.e, e.e});
                    chk("overrun", {ovr_m, ovr_l}, {e.o, e.o});
                    chk("busy_lsb", busy_l, 0);
                end
            end else begin
                chk("spurious_pulse", {err_m, err_l, ovr_m, ovr_l}, 0);
            end
            prev_busy = busy_m;
        end
    end

    initial begin
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b1;
        tick();
        repeat (20) send_bit(1'b1, 4, 1'b0);
        chk("idle_busy", {busy_m, busy_l}, 0);
        chk("idle_valid", {valid_m, valid_l}, 0);
        send_frame(8'h93, 1'b1, 4, 1'b0);
        do_ack();
        send_frame(8'h93, 1'b0, 4, 1'b0);
        send_frame(8'h5A, 1'b1, 4, 1'b0);
        do_ack();
        send_frame(8'h93, 1'b1, 1, 1'b0);
        send_frame(8'h0F, 1'b1, 1, 1'b0);
        do_ack();
        send_frame(8'h93, 1'b1, 1, 1'b0);
        send_frame(8'h0F, 1'b1, 1, 1'b1);
        do_ack();
        send_bit(1'b0, 4, 1'b0);
        for (int i = 7; i >= 4; i--) send_bit(1'b1, 4, 1'b0);
        rst = 1'b0;
        #1;
        chk_reset("async_reset");
        mv  = 1'b0;
        mwm = '0;
        mwl = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        send_frame(8'hC3, 1'b1, 4, 1'b0);
        do_ack();
        send_frame(rev8(8'h93), 1'b1, 2, 1'b0);
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom), $urandom_range(0, 5) != 0, $urandom_range(1, 4), $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) do_ack();
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) send_bit(1'b1, $urandom_range(1, 4), 1'b0);
        end
        repeat (3) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sipo_receiver.md
# sipo_receiver

Serial-in/parallel-out frame receiver: the receive end of the team's PISO serial link. It samples a one-bit serial line on a bit-enable strobe, detects a start bit, shifts in WIDTH data bits MSB first, and checks the stop bit. It then presents the word on a parallel bus with a valid/ack handshake. It sits between the serial line, driven by the PISO transmitter in the same clock domain, and the board-level logic that drives the LEDs.

## Interface
- WIDTH, 8: data bits per frame.
- MSB_FIRST, 1: 1 means the first data bit received lands in bit WIDTH-1; 0 means it lands in bit 0.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous and active-low; asserted when 0.
- bit_en  input  1  one-clk strobe marking a bit period; ser_in is sampled only on cycles where bit_en=1.
- ser_in  input  1  serial line; idles high; synchronous to clk.
- par_out  output  WIDTH  last correctly framed word.
- par_valid  output  1  par_out holds an unconsumed word.
- par_ack  input  1  consumer takes the word; meaningful only while par_valid=1.
- frame_err  output  1  one-clk pulse: the stop bit was sampled as 0.
- overrun  output  1  one-clk pulse: a new word overwrote an unacknowledged word.
- busy  output  1  a frame is in progress (state is not IDLE).

## Operation
- Frame format: start bit (0), then WIDTH data bits, then stop bit (1). There is one bit per bit_en strobe.
- States:
  - IDLE: on bit_en with ser_in=0, go to DATA and clear bit_cnt. On bit_en with ser_in=1, stay in IDLE.
  - DATA: on each bit_en, shift ser_in into shift_reg (direction set by MSB_FIRST) and increment bit_cnt. On the bit_en that captures data bit WIDTH-1, go to STOP.
  - STOP: on bit_en with ser_in=1, load par_out from shift_reg, set par_valid, and go to IDLE. On bit_en with ser_in=0, pulse frame_err, leave par_out and par_valid unchanged, and go to IDLE.
- After a framing error, the receiver re-arms directly in IDLE. It does not hunt for a break; a 0 on the next strobe is treated as a new start bit.
- Handshake:
  - par_valid rises on a good stop bit.
  - par_valid falls on the cycle after par_ack=1 is sampled while par_valid=1.
  - par_ack while par_valid=0 is ignored.
- Overrun: a good stop bit while par_valid=1 and par_ack=0 overwrites par_out, keeps par_valid=1, and pulses overrun.
- Good stop and par_ack=1 in the same cycle: par_out takes the new word, par_valid stays 1, and there is no overrun.
- bit_cnt is $clog2(WIDTH+1) bits wide and never wraps past WIDTH-1 in DATA.
- Cycles with bit_en=0 change no state, except for par_ack handling.

## Timing
- Reset values: par_out=0, par_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, shift_reg=0, bit_cnt=0.
- Reset asserted mid-frame aborts the frame immediately. No partial word and no error pulse are produced.
- All outputs are registered.
- Latency:
  - par_valid, par_out, frame_err and overrun update on the same clk edge that samples the stop bit with bit_en=1.
  - busy rises on the edge that samples the start bit and falls on the edge that samples the stop bit.
- A frame occupies WIDTH+2 bit_en strobes. Back-to-back frames are supported: a start bit on the very next strobe after the stop bit is accepted.
- bit_en may be tied high, giving one bit per clk. The receiver must still operate correctly in that case.

## Structure
- Shared package sipo_pkg holds:
  - state encoding constants ST_IDLE, ST_DATA, ST_STOP (2-bit);
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- The PISO transmitter imports the same frame constants so both ends agree on the format.
- Single module, no sub-modules. The state register, bit counter, shift register and output/handshake register are separate always blocks.

## Test plan
- Reset, then ser_in=1 held for 20 strobes: busy=0, par_valid=0, and no pulses.
- Frame 0, 10010011, 1 with WIDTH=8, MSB_FIRST=1, bit_en every 4th clk: par_out=8'h93 and par_valid=1 on the stop-bit edge. Then par_ack=1 for one clk gives par_valid=0 on the next clk.
- Same frame with a stop bit of 0: frame_err pulses for exactly one clk, and par_valid and par_out keep their previous values. The following good frame 8'h5A is received correctly.
- Two back-to-back frames 8'h93 then 8'h0F with no ack, and bit_en tied high: par_out=8'h0F, par_valid=1, and overrun pulses once at the second stop bit. Repeat with par_ack=1 on the second stop edge: no overrun pulse.
- rst pulled low after the 4th data bit of a frame: all outputs go to reset values asynchronously. After release, a full frame 8'hC3 decodes correctly.
- MSB_FIRST=0, frame carrying 8'h93 sent LSB first: par_out=8'h93.
